vram_write_queue: RTL and testbench

//   Downstream of cpu: buffers the CPU's video-memory writes (mem_we_v, mem_addr, b)
//   in a small FIFO and drains them to the video RAM write port only on cycles when
//   the display side releases that port (vram_free, e.g. during blanking).
//   The CPU has no stall input. Writes arriving while the queue is full are dropped
//   and flagged in a sticky overflow bit.

---
 rtl/vram_write_queue.sv | 80 ++++++++
 tb/tb_vram_write_queue.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vram_write_queue.sv
// Buffers CPU video-memory writes in a small FIFO.
// Drains one entry per cycle to the video RAM write port whenever the display side frees it.
module vram_write_queue #(
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_we_v,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] b,
  input  logic              vram_free,
  input  logic              overflow_clr,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_din,
  output logic [AW:0]       q_count,
  output logic              q_empty,
  output logic              q_full,
  output logic              overflow
);

  localparam int EW = ADDR_W + DATA_W;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [EW-1:0] entry [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count_next;
  logic          pop, push, drop;

  // Decisions use only registered state, so a write into an empty queue cannot be popped in the same cycle.
  assign pop  = vram_free & ~q_empty;
  assign push = mem_we_v & (~q_full | pop);
  assign drop = mem_we_v & q_full & ~pop;

  always_comb begin
    count_next = q_count;
    case ({push, pop})
      2'b10:   count_next = q_count + (AW+1)'(1);
      2'b01:   count_next = q_count - (AW+1)'(1);
      default: count_next = q_count;
    endcase
  end

  // NOTE: the storage array has no reset; the pointers alone define validity, so it maps to plain RAM.
  always_ff @(posedge clock) begin
    if (push) entry[wr_ptr] <= {mem_addr, b};
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      q_count   <= '0;
      q_empty   <= 1'b1;
      q_full    <= 1'b0;
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_din  <= '0;
      overflow  <= 1'b0;
    end else begin
      vram_we <= pop;
      if (pop) begin
        {vram_addr, vram_din} <= entry[rd_ptr];
        rd_ptr                <= rd_ptr + AW'(1);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      q_count <= count_next;
      q_empty <= (count_next == '0);
      q_full  <= (count_next == FULL_COUNT);
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vram_write_queue.sv
// Directed testbench for vram_write_queue.
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.
module tb_vram_write_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_we_v;
  logic [15:0] mem_addr;
  logic [7:0]  b;
  logic        vram_free;
  logic        overflow_clr;
  logic        vram_we;
  logic [15:0] vram_addr;
  logic [7:0]  vram_din;
  logic [3:0]  q_count;
  logic        q_empty;
  logic        q_full;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  vram_write_queue #(.DEPTH(8), .AW(3), .ADDR_W(16), .DATA_W(8)) dut (
    .clock(clock), .reset(reset), .mem_we_v(mem_we_v), .mem_addr(mem_addr), .b(b),
    .vram_free(vram_free), .overflow_clr(overflow_clr), .vram_we(vram_we),
    .vram_addr(vram_addr), .vram_din(vram_din), .q_count(q_count), .q_empty(q_empty),
    .q_full(q_full), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_write(input logic we, input logic [15:0] a, input logic [7:0] d);
    mem_we_v = we;
    mem_addr = a;
    b        = d;
  endtask

  initial begin
    int sent, rcvd, cyc;
    logic free_applied, we_applied;

    reset = 1'b0; vram_free = 1'b0; overflow_clr = 1'b0;
    set_write(1'b0, 16'h0, 8'h0);
    #1;

    // 1. Reset for two cycles with random inputs.
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem_we_v = 1'($urandom); mem_addr = 16'($urandom); b = 8'($urandom);
      vram_free = 1'($urandom); overflow_clr = 1'($urandom);
      tick();
    end
    check("rst_vram_we", vram_we, 0);
    check("rst_q_count", q_count, 0);
    check("rst_q_empty", q_empty, 1);
    check("rst_q_full", q_full, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b0; overflow_clr = 1'b0; vram_free = 1'b1;
    set_write(1'b0, 16'h0, 8'h0);

    // 2. Single write, vram_free held high: one pulse, one cycle after the write becomes visible.
    set_write(1'b1, 16'h1234, 8'hAB);
    tick();
    set_write(1'b0, 16'h0, 8'h0);
    check("t2_no_bypass", vram_we, 0);
    check("t2_count1", q_count, 1);
    tick();
    check("t2_we", vram_we, 1);
    check("t2_addr", vram_addr, 16'h1234);
    check("t2_din", vram_din, 8'hAB);
    check("t2_empty", q_empty, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_single_pulse", vram_we, 0);
    end
    check("t2_addr_hold", vram_addr, 16'h1234);

    // 3. Fill with the port busy, overflow on the ninth write (with clear asserted: set wins).
    vram_free = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_write(1'b1, 16'h0100 + 16'(i), 8'(i));
      overflow_clr = (i == 8);
      tick();
      if (i == 7) begin
        check("t3_full_after8", q_full, 1);
        check("t3_count8", q_count, 8);
        check("t3_no_ovf_yet", overflow, 0);
      end
    end
    set_write(1'b0, 16'h0, 8'h0);
    overflow_clr = 1'b0;
    check("t3_overflow", overflow, 1);
    check("t3_count_after_drop", q_count, 8);
    vram_free = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      check("t3_drain_we", vram_we, 1);
      check("t3_drain_din", vram_din, j);
      check("t3_drain_addr", vram_addr, 16'h0100 + 16'(j));
    end
    check("t3_empty", q_empty, 1);
    check("t3_count0", q_count, 0);
    tick();
    check("t3_drain_end", vram_we, 0);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("t3_ovf_cleared", overflow, 0);

    // 4. Write into a full queue on the same edge as a pop: accepted, drained last.
    vram_free = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_write(1'b1, 16'h0200 + 16'(i), 8'h10 + 8'(i));
      tick();
    end
    check("t4_full", q_full, 1);
    vram_free = 1'b1;
    set_write(1'b1, 16'h02EE, 8'hEE);
    tick();
    set_write(1'b0, 16'h0, 8'h0);
    check("t4_pop_we", vram_we, 1);
    check("t4_pop_din", vram_din, 8'h10);
    check("t4_count_stays8", q_count, 8);
    check("t4_still_full", q_full, 1);
    check("t4_no_overflow", overflow, 0);
    for (int j = 1; j < 8; j++) begin
      tick();
      check("t4_drain_din", vram_din, 8'h10 + 8'(j));
    end
    tick();
    check("t4_last_we", vram_we, 1);
    check("t4_last_din", vram_din, 8'hEE);
    check("t4_last_addr", vram_addr, 16'h02EE);
    check("t4_empty", q_empty, 1);

    // 5. 20 writes (two of every three cycles) while vram_free alternates 1,0,1,0...
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 20 && cyc < 120) begin
      we_applied   = (sent < 20) && (cyc % 3 != 2);
      free_applied = (cyc % 2 == 0);
      set_write(we_applied, 16'h0300 + 16'(sent), 8'h40 + 8'(sent));
      vram_free = free_applied;
      tick();
      if (we_applied) sent++;
      if (!free_applied) check("t5_no_pop_when_busy", vram_we, 0);
      if (vram_we) begin
        check("t5_din", vram_din, 8'h40 + 8'(rcvd));
        check("t5_addr", vram_addr, 16'h0300 + 16'(rcvd));
        rcvd++;
      end
      cyc++;
    end
    set_write(1'b0, 16'h0, 8'h0);
    check("t5_all_received", rcvd, 20);
    check("t5_overflow", overflow, 0);
    check("t5_empty", q_empty, 1);

    // 6. Reset in the middle of a drain discards what is left.
    vram_free = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_write(1'b1, 16'h0600 + 16'(i), 8'h60 + 8'(i));
      tick();
    end
    set_write(1'b0, 16'h0, 8'h0);
    check("t6_count6", q_count, 6);
    vram_free = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      check("t6_pre_din", vram_din, 8'h60 + 8'(j));
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_we", vram_we, 0);
    check("t6_rst_count", q_count, 0);
    check("t6_rst_empty", q_empty, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_no_stale", vram_we, 0);
    end
    set_write(1'b1, 16'h7777, 8'h77);
    tick();
    set_write(1'b0, 16'h0, 8'h0);
    tick();
    check("t6_new_we", vram_we, 1);
    check("t6_new_addr", vram_addr, 16'h7777);
    check("t6_new_din", vram_din, 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
